multicycle_control_unit: RTL and testbench

Multi-cycle, parametrised control sequencer for the 8-bit CPU. It replaces the single-cycle combinational opcode decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM states and waits on instruction and data-memory handshakes. It drives the same datapath control signals, but only in the cycle where they take effect. It sits between the instruction register/fetch port and the datapath muxes, register file, PC and RA registers.

---
 rtl/multicycle_control_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle control sequencer for the 8-bit CPU. Each instruction steps
//   through FETCH -> DECODE -> EXEC (-> MEM) and the datapath controls are
//   driven only in the cycle where they take effect.
//
// Parameters
//   OPC_W   opcode width (>=4); any set bit above bit 3 marks an illegal opcode
//   ALUOP_W ALUOP width (>=3); upper bits driven 0
//   CNT_W   retired-instruction counter width (used with CU_PERF_CNT_EN)
//
// Optional feature macro: CU_PERF_CNT_EN adds the instret counter/port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opCode, instr_valid fetched opcode / valid; fetch_req requests a fetch
//   zero_flag           ALU zero flag, used only in EXEC
//   mem_req, mem_ready  data memory handshake
//   resume, halted      leave HALT / in HALT
//   PC_Enable .. ALUOP  datapath enables, mux selects, ALU operation
//   instret             retired-instruction count (macro only)
module multicycle_control_unit #(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opCode,
  input  logic               instr_valid,
  output logic               fetch_req,
  input  logic               zero_flag,
  output logic               mem_req,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               halted,
  output logic               PC_Enable,
  output logic               RA_Enable,
  output logic               Reg_const4,
  output logic               RegWrite_Enable,
  output logic               Reg_Imm,
  output logic               MemWrite_Enable,
  output logic [1:0]         PC_RA_ALU_REG,
  output logic [1:0]         Alu_Move_Mem,
  output logic [1:0]         Reg_4_PC,
  output logic [ALUOP_W-1:0] ALUOP
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   instret
`endif
);

  // Elaboration-time parameter sanity check
  if (OPC_W < 4 || ALUOP_W < 3 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_control_unit: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [OPC_W-1:0] r_opcode;
  logic [OPC_W-1:0] w_opc_upper;
  logic [3:0]       w_op_lo;
  logic             w_illegal;
  logic             w_is_read;

  // Opcode split: low nibble selects the instruction, any upper bit makes it illegal
  assign w_op_lo     = r_opcode[3:0];
  assign w_opc_upper = r_opcode >> 4;
  assign w_illegal   = |w_opc_upper;
  assign w_is_read   = (w_op_lo == 4'h3);

  // State and latched opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && instr_valid) begin
        r_opcode <= opCode;
      end
    end
  end

  // Next state and per-cycle control outputs
  always_comb begin
    w_next_state    = r_state;
    fetch_req       = 1'b0;
    mem_req         = 1'b0;
    halted          = 1'b0;
    PC_Enable       = 1'b0;
    RA_Enable       = 1'b0;
    Reg_const4      = 1'b0;
    RegWrite_Enable = 1'b0;
    Reg_Imm         = 1'b0;
    MemWrite_Enable = 1'b0;
    PC_RA_ALU_REG   = 2'b00;
    Alu_Move_Mem    = 2'b00;
    Reg_4_PC        = 2'b00;
    ALUOP           = '0;

    case (r_state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        w_next_state = S_EXEC;
      end

      S_EXEC: begin
        w_next_state = S_FETCH;
        if (w_illegal) begin
          PC_Enable = 1'b1;
        end else begin
          case (w_op_lo)
            4'h0: w_next_state = S_HALT;
            4'h1: begin
              PC_Enable       = 1'b1;
              Reg_const4      = 1'b1;
              RegWrite_Enable = 1'b1;
              Reg_Imm         = 1'b1;
              Reg_4_PC        = 2'b01;
              ALUOP           = ALUOP_W'(3'b010);
            end
            4'h2: begin
              PC_Enable       = 1'b1;
              Reg_const4      = 1'b1;
              RegWrite_Enable = 1'b1;
              Reg_Imm         = 1'b1;
              ALUOP           = ALUOP_W'(3'b101);
            end
            4'h3, 4'h4: w_next_state = S_MEM;
            4'h5: begin
              PC_Enable       = 1'b1;
              RegWrite_Enable = 1'b1;
              Alu_Move_Mem    = 2'b01;
            end
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
              PC_Enable       = 1'b1;
              RegWrite_Enable = 1'b1;
              case (w_op_lo)
                4'h6:    ALUOP = ALUOP_W'(3'b001);
                4'h7:    ALUOP = ALUOP_W'(3'b011);
                4'h8:    ALUOP = ALUOP_W'(3'b100);
                4'h9:    ALUOP = ALUOP_W'(3'b101);
                default: ALUOP = ALUOP_W'(3'b110);
              endcase
            end
            4'hB: begin
              PC_Enable     = 1'b1;
              RA_Enable     = 1'b1;
              PC_RA_ALU_REG = 2'b11;
            end
            4'hC: begin
              PC_Enable = 1'b1;
              if (zero_flag) begin
                RA_Enable     = 1'b1;
                PC_RA_ALU_REG = 2'b11;
              end
            end
            4'hD: begin
              PC_Enable     = 1'b1;
              PC_RA_ALU_REG = 2'b01;
            end
            4'hE, 4'hF: begin
              PC_Enable     = 1'b1;
              Reg_Imm       = 1'b1;
              Reg_4_PC      = 2'b10;
              ALUOP         = ALUOP_W'(3'b001);
              // Conditional branch falls through to PC+4 when not zero
              PC_RA_ALU_REG = (w_op_lo == 4'hE || zero_flag) ? 2'b10 : 2'b00;
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        if (w_is_read) begin
          Alu_Move_Mem = 2'b10;
        end
        if (mem_ready) begin
          PC_Enable       = 1'b1;
          RegWrite_Enable = w_is_read;
          MemWrite_Enable = ~w_is_read;
          w_next_state    = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          PC_Enable    = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      default: w_next_state = S_FETCH;
    endcase

    // Reset wins over any completing transition: suppress all write pulses
    if (rst) begin
      PC_Enable       = 1'b0;
      RA_Enable       = 1'b0;
      RegWrite_Enable = 1'b0;
      MemWrite_Enable = 1'b0;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] r_instret;

  // Retired-instruction counter, one count per PC_Enable pulse, wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (PC_Enable) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (OPC_W=5 to reach illegal
// opcodes, ALUOP_W=4 to see the zero-extended ALUOP, CNT_W=4 for wrap).
module tb_multicycle_control_unit;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [OPC_W-1:0]   opCode;
  logic               instr_valid, fetch_req, zero_flag, mem_req, mem_ready;
  logic               resume, halted;
  logic               PC_Enable, RA_Enable, Reg_const4, RegWrite_Enable, Reg_Imm, MemWrite_Enable;
  logic [1:0]         PC_RA_ALU_REG, Alu_Move_Mem, Reg_4_PC;
  logic [ALUOP_W-1:0] ALUOP;
`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0]   instret;
`endif

  multicycle_control_unit #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .instr_valid(instr_valid),
    .fetch_req(fetch_req), .zero_flag(zero_flag), .mem_req(mem_req),
    .mem_ready(mem_ready), .resume(resume), .halted(halted),
    .PC_Enable(PC_Enable), .RA_Enable(RA_Enable), .Reg_const4(Reg_const4),
    .RegWrite_Enable(RegWrite_Enable), .Reg_Imm(Reg_Imm),
    .MemWrite_Enable(MemWrite_Enable), .PC_RA_ALU_REG(PC_RA_ALU_REG),
    .Alu_Move_Mem(Alu_Move_Mem), .Reg_4_PC(Reg_4_PC), .ALUOP(ALUOP)
`ifdef CU_PERF_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  // Output bundle: fetch_req mem_req halted PC RA c4 RegW Imm MemW | PRA AMM R4PC | ALUOP
  logic [18:0] dut_vec;
  assign dut_vec = {fetch_req, mem_req, halted, PC_Enable, RA_Enable, Reg_const4,
                    RegWrite_Enable, Reg_Imm, MemWrite_Enable,
                    PC_RA_ALU_REG, Alu_Move_Mem, Reg_4_PC, ALUOP};

  localparam logic [18:0] RESET_VEC = 19'h40000;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the instruction's phase, the latched opcode and current inputs.
  // Phases: 0 fetch, 1 decode, 2 execute, 3 memory, 4 halted.
  function automatic logic [18:0] expect_vec(input int ph, input int opc, input bit zf,
                                             input bit mr, input bit res, input bit rs);
    bit fr = 0, mq = 0, hl = 0, pc = 0, ra = 0, c4 = 0, rw = 0, im = 0, mw = 0;
    logic [1:0] pra = 0, amm = 0, r4 = 0;
    logic [3:0] alu = 0;
    case (ph)
      0: fr = 1;
      2: begin
        if (opc > 15) pc = 1;
        else case (opc)
          1:  begin pc = 1; c4 = 1; rw = 1; im = 1; r4 = 1; alu = 2; end
          2:  begin pc = 1; c4 = 1; rw = 1; im = 1; alu = 5; end
          5:  begin pc = 1; rw = 1; amm = 1; end
          6:  begin pc = 1; rw = 1; alu = 1; end
          7:  begin pc = 1; rw = 1; alu = 3; end
          8:  begin pc = 1; rw = 1; alu = 4; end
          9:  begin pc = 1; rw = 1; alu = 5; end
          10: begin pc = 1; rw = 1; alu = 6; end
          11: begin pc = 1; ra = 1; pra = 3; end
          12: begin pc = 1; if (zf) begin ra = 1; pra = 3; end end
          13: begin pc = 1; pra = 1; end
          14: begin pc = 1; im = 1; pra = 2; r4 = 2; alu = 1; end
          15: begin pc = 1; im = 1; pra = zf ? 2'd2 : 2'd0; r4 = 2; alu = 1; end
          default: ;
        endcase
      end
      3: begin
        mq = 1;
        if (opc == 3) amm = 2;
        if (mr) begin pc = 1; if (opc == 3) rw = 1; else mw = 1; end
      end
      4: begin hl = 1; if (res) pc = 1; end
      default: ;
    endcase
    if (rs) begin pc = 0; ra = 0; rw = 0; mw = 0; end
    return {fr, mq, hl, pc, ra, c4, rw, im, mw, pra, amm, r4, alu};
  endfunction

  // Reference model: checked every cycle on the falling edge, then advanced
  bit chk_en = 0;
  int m_ph  = 0;
  int m_opc = 0;
  int m_cnt = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [18:0] e;
      e = expect_vec(m_ph, m_opc, zero_flag, mem_ready, resume, rst);
      chk("cycle_outputs", 32'(dut_vec), 32'(e));
`ifdef CU_PERF_CNT_EN
      chk("cycle_instret", 32'(instret), 32'(m_cnt));
`endif
      if (rst) m_cnt = 0;
      else if (e[15]) m_cnt = (m_cnt + 1) % 16;
      if (rst) begin
        m_ph = 0; m_opc = 0;
      end else case (m_ph)
        0: if (instr_valid) begin m_ph = 1; m_opc = int'(opCode); end
        1: m_ph = 2;
        2: m_ph = (m_opc == 0) ? 4 : ((m_opc == 3 || m_opc == 4) ? 3 : 0);
        3: if (mem_ready) m_ph = 0;
        4: if (resume) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [18:0] snap;

  // Fetch (after pre stall cycles), decode, execute; snapshot outputs in EXEC.
  // Ignored inputs are driven active outside the states that use them.
  task automatic exec_instr(input int opc, input bit z, input int pre);
    zero_flag = ~z; mem_ready = 1'b1; resume = 1'b1;
    instr_valid = 1'b0; opCode = OPC_W'(opc);
    repeat (pre) tick;
    instr_valid = 1'b1; tick;
    instr_valid = 1'b0; opCode = ~OPC_W'(opc); tick;
    zero_flag = z; mem_ready = 1'b0; resume = 1'b0;
    @(negedge clk); snap = dut_vec;
    tick;
    zero_flag = ~z;
  endtask

  int c_mq, c_amm, c_rw, c_pc, c_hl;
  bit rw_last;

  initial begin
    rst = 1'b1; opCode = '0; instr_valid = 1'b0; zero_flag = 1'b0;
    mem_ready = 1'b0; resume = 1'b0;
    tick;
    chk_en = 1;
    tick;
    rst = 1'b0;

    // add with instr_valid held high
    opCode = 5'h06; instr_valid = 1'b1;
    @(negedge clk); chk("reset_vec", 32'(dut_vec), 32'(RESET_VEC));
    tick;
    @(negedge clk); chk("add_decode", 32'(dut_vec), 32'h0);
    tick;
    @(negedge clk); chk("add_exec", {PC_Enable, RegWrite_Enable, 26'h0, ALUOP}, {2'b11, 26'h0, 4'h1});
    instr_valid = 1'b0;
    tick;
    @(negedge clk); chk("add_refetch", 32'(fetch_req), 32'h1);
    tick;

    // opcode sweep including illegal opcodes and a fetch stall
    exec_instr(1, 0, 2);  chk("lui_exec", 32'(snap), 32'h0B812);
    exec_instr(2, 1, 0);
    exec_instr(5, 0, 0);  chk("move_exec", 32'(snap), 32'h09040);
    for (int op = 7; op <= 14; op++) exec_instr(op, 0, 0);
    exec_instr(12, 1, 0); chk("callz_taken", 32'(snap), 32'h0C300);
    exec_instr(15, 0, 1); chk("bz_not_taken", {30'h0, snap[9:8], 2'b00} | 32'(snap[5:4]), 32'h2);
    exec_instr(15, 1, 0); chk("bz_taken", {28'h0, snap[9:8], snap[5:4]}, 32'hA);
    exec_instr(5'h13, 0, 0); chk("illegal_13", 32'(snap), 32'h08000);
    exec_instr(5'h10, 0, 0); chk("illegal_10", 32'(snap), 32'h08000);
    tick;
    @(negedge clk); chk("illegal_not_halt", 32'(fetch_req), 32'h1);

    // read with three stall cycles
    exec_instr(3, 0, 0);
    c_mq = 0; c_amm = 0; c_rw = 0; c_pc = 0; rw_last = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      c_mq += int'(mem_req); c_amm += int'(Alu_Move_Mem == 2'b10);
      c_rw += int'(RegWrite_Enable); c_pc += int'(PC_Enable);
      if (i == 3) rw_last = RegWrite_Enable;
      tick;
    end
    mem_ready = 1'b0;
    chk("rd_memreq_cycles", 32'(c_mq), 32'd4);
    chk("rd_amm_cycles", 32'(c_amm), 32'd4);
    chk("rd_regwrite_pulses", 32'(c_rw), 32'd1);
    chk("rd_pc_pulses", 32'(c_pc), 32'd1);
    chk("rd_regwrite_on_ready", 32'(rw_last), 32'd1);

    // write without stall
    exec_instr(4, 1, 0);
    mem_ready = 1'b1;
    @(negedge clk); chk("wr_done", {29'h0, mem_req, MemWrite_Enable, PC_Enable}, 32'h7);
    tick; mem_ready = 1'b0;

    // halt for five cycles, then resume
    exec_instr(0, 0, 0);
    c_hl = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); c_hl += int'(halted && !PC_Enable); tick;
    end
    chk("halt_cycles", 32'(c_hl), 32'd5);
    resume = 1'b1;
    @(negedge clk); chk("resume_pc", {30'h0, halted, PC_Enable}, 32'h3);
    tick; resume = 1'b0;
    @(negedge clk); chk("resume_refetch", 32'(dut_vec), 32'(RESET_VEC));
    tick;

    // reset during a write stall
    exec_instr(4, 0, 0);
    tick; tick;
    rst = 1'b1;
    @(negedge clk); chk("rst_mem_cycle", {29'h0, mem_req, MemWrite_Enable, PC_Enable}, 32'h4);
    tick; rst = 1'b0;
    @(negedge clk); chk("rst_after_mem", 32'(dut_vec), 32'(RESET_VEC));
    tick;

    // reset together with resume
    exec_instr(0, 0, 0);
    tick;
    rst = 1'b1; resume = 1'b1;
    @(negedge clk); chk("rst_resume_pc", 32'(PC_Enable), 32'h0);
    tick; rst = 1'b0; resume = 1'b0;
    @(negedge clk); chk("rst_resume_after", 32'(dut_vec), 32'(RESET_VEC));
    tick;

`ifdef CU_PERF_CNT_EN
    // 17 retirements wrap a 4-bit counter to 1
    rst = 1'b1; tick; rst = 1'b0;
    repeat (17) exec_instr(6, 0, 0);
    @(negedge clk); chk("instret_wrap", 32'(instret), 32'h1);
`endif

    tick;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
